// File: rtl/trace_replay_engine.sv
// Replays a preloaded address trace over a valid/ready request port, one request at a time,
// and accumulates issued/hit/miss counts from the cache responses.
module trace_replay_engine #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned PTR_W  = 10,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_we_i,
    input  logic [PTR_W-1:0]  load_addr_i,
    input  logic [ADDR_W-1:0] load_data_i,
    input  logic [PTR_W:0]    trace_len_i,
    input  logic              start_i,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              resp_valid_i,
    input  logic              resp_hit_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  issued_cnt_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int unsigned Depth = 2 ** PTR_W;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e state_q, state_d;

    // One bit wider than the memory index so a full-depth trace length is representable.
    logic [PTR_W:0]    ptr_q, ptr_d;
    logic [PTR_W:0]    len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    logic [ADDR_W-1:0] mem [Depth];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + 1'b1;
    endfunction

    assign mem_we    = load_we_i && (state_q == StIdle);
    assign mem_rdata = mem[ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        hit_d    = hit_q;
        miss_d   = miss_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d    = trace_len_i;
                    ptr_d    = '0;
                    issued_d = '0;
                    hit_d    = '0;
                    miss_d   = '0;
                    state_d  = (trace_len_i != '0) ? StFetch : StDone;
                end
            end
            StFetch: begin
                addr_d  = mem_rdata;
                state_d = StIssue;
            end
            StIssue: begin
                if (req_ready_i) begin
                    issued_d = sat_inc(issued_q);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (resp_valid_i) begin
                    if (resp_hit_i) begin
                        hit_d = sat_inc(hit_q);
                    end else begin
                        miss_d = sat_inc(miss_q);
                    end
                    ptr_d   = ptr_q + 1'b1;
                    state_d = (ptr_d == len_q) ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            issued_q <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign req_valid_o  = (state_q == StIssue);
    assign req_addr_o   = addr_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign issued_cnt_o = issued_q;
    assign hit_cnt_o    = hit_q;
    assign miss_cnt_o   = miss_q;

endmodule

// File: tb/tb_trace_replay_engine.sv
// Randomized bench for trace_replay_engine: a responder models the cache, a monitor checks
// requests and final counts against expectations queued when each replay is started.
module tb_trace_replay_engine;

    localparam int CntSat = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  trace_len;
    logic        start;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic        busy;
    logic        done;
    logic [3:0]  issued_cnt;
    logic [3:0]  hit_cnt;
    logic [3:0]  miss_cnt;

    typedef struct {
        int issued;
        int hit;
        int miss;
    } cnt_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [16];
    logic [31:0] exp_addr_q [$];
    bit          hit_q [$];
    cnt_t        exp_done_q [$];

    int hs_count = 0;
    int done_count = 0;
    int done_base = 0;
    int valid_cycles = 0;
    int stall_cycles = 0;
    bit hs_seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    bit outstanding;
    int delay;
    int dmin = 0;
    int dmax = 0;
    bit rand_ready = 1'b0;
    int stall_left = 0;
    bit spur_en = 1'b0;

    trace_replay_engine #(
        .ADDR_W(32),
        .PTR_W (4),
        .CNT_W (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_we_i   (load_we),
        .load_addr_i (load_addr),
        .load_data_i (load_data),
        .trace_len_i (trace_len),
        .start_i     (start),
        .req_valid_o (req_valid),
        .req_addr_o  (req_addr),
        .req_ready_i (req_ready),
        .resp_valid_i(resp_valid),
        .resp_hit_i  (resp_hit),
        .busy_o      (busy),
        .done_o      (done),
        .issued_cnt_o(issued_cnt),
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
    );

    initial forever #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > CntSat) ? CntSat : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Cache responder: owns req_ready / resp_valid / resp_hit.
    initial begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        outstanding = 1'b0;
        delay       = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
            resp_hit   = 1'b0;
            if (rst) begin
                outstanding = 1'b0;
                req_ready   = 1'b0;
            end else begin
                if (hs_seen) begin
                    outstanding = 1'b1;
                    delay = dmin + int'($urandom_range(0, dmax - dmin));
                end
                if (outstanding) begin
                    if (delay == 0) begin
                        resp_valid  = 1'b1;
                        resp_hit    = (hit_q.size() != 0) ? hit_q.pop_front() : 1'b0;
                        outstanding = 1'b0;
                    end else begin
                        delay--;
                    end
                end else if (spur_en && $urandom_range(0, 1) == 1) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'($urandom);
                end
                if (stall_left > 0) begin
                    req_ready = 1'b0;
                    if (req_valid) stall_left--;
                end else begin
                    req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, pops expectations when the DUT presents output.
    initial forever begin
        @(negedge clk);
        hs_seen = 1'b0;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (req_valid) begin
                valid_cycles++;
                if (prev_stall) check("addr_stable", req_addr, prev_addr);
                if (req_ready) begin
                    hs_count++;
                    hs_seen    = 1'b1;
                    prev_stall = 1'b0;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got 0x%0h, expected no request", req_addr);
                    end else begin
                        check("req_addr", req_addr, exp_addr_q.pop_front());
                    end
                end else begin
                    stall_cycles++;
                    prev_stall = 1'b1;
                    prev_addr  = req_addr;
                end
            end else begin
                if (prev_stall) check("valid_held", 32'(req_valid), 32'd1);
                prev_stall = 1'b0;
            end
            if (done) begin
                done_count++;
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done pulse, expected none");
                end else begin
                    cnt_t e;
                    e = exp_done_q.pop_front();
                    check("issued_cnt", 32'(issued_cnt), e.issued);
                    check("hit_cnt", 32'(hit_cnt), e.hit);
                    check("miss_cnt", 32'(miss_cnt), e.miss);
                end
            end
        end
    end

    task automatic load(input logic [3:0] idx, input logic [31:0] data);
        load_we   = 1'b1;
        load_addr = idx;
        load_data = data;
        model_mem[idx] = data;
        @(posedge clk);
        #1;
        load_we = 1'b0;
    endtask

    task automatic run_replay(input int n, input logic [15:0] hits, input bit do_load,
                              input logic [3:0] li, input logic [31:0] ld, output cnt_t e);
        int pop = 0;
        if (do_load) begin
            model_mem[li] = ld;
            load_we   = 1'b1;
            load_addr = li;
            load_data = ld;
        end
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(model_mem[i]);
            hit_q.push_back(hits[i]);
            pop += int'(hits[i]);
        end
        e.issued = sat(n);
        e.hit    = sat(pop);
        e.miss   = sat(n - pop);
        exp_done_q.push_back(e);
        done_base = done_count;
        trace_len = 5'(n);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        load_we = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while (done_count == done_base && lat < budget) begin
            @(posedge clk);
            lat++;
        end
        #1;
        if (done_count == done_base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected one", budget);
        end else begin
            check("busy_after_done", 32'(busy), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            check("done_once", 32'(done_count - done_base), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cnt_t e;
        int lat;
        int v0;
        int s0;
        int hb;
        rst = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        trace_len = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnts", 32'({issued_cnt, hit_cnt, miss_cnt}), 32'd0);
        @(posedge clk);
        #1;

        // Basic replay with a fixed hit pattern.
        for (int i = 0; i < 4; i++) load(4'(i), 32'(4 * i));
        run_replay(4, 16'b0110, 1'b0, '0, '0, e);
        wait_done(40, lat);

        // Empty trace.
        v0 = valid_cycles;
        run_replay(0, '0, 1'b0, '0, '0, e);
        wait_done(5, lat);
        check("len0_latency_ok", 32'(lat <= 2), 32'd1);
        check("len0_no_req", 32'(valid_cycles - v0), 32'd0);

        // Back-pressure on the first entry.
        stall_left = 5;
        s0 = stall_cycles;
        run_replay(4, 16'($urandom), 1'b0, '0, '0, e);
        wait_done(60, lat);
        check("stall_cycles", 32'(stall_cycles - s0), 32'd5);

        // Spurious responses and a second start while busy.
        spur_en = 1'b1; dmin = 1; dmax = 2;
        run_replay(4, 16'($urandom), 1'b0, '0, '0, e);
        repeat (3) @(posedge clk);
        #1;
        trace_len = 5'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(80, lat);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("idle_issued_hold", 32'(issued_cnt), e.issued);
        check("idle_hit_hold", 32'(hit_cnt), e.hit);
        check("idle_miss_hold", 32'(miss_cnt), e.miss);
        spur_en = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in WAIT of entry 2, then restart.
        dmin = 3; dmax = 3;
        hb = hs_count;
        run_replay(4, 16'($urandom), 1'b0, '0, '0, e);
        lat = 0;
        while (hs_count < hb + 2 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("reset_test_reached_entry2", 32'(hs_count - hb), 32'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_req_valid", 32'(req_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_req_addr", req_addr, 32'd0);
        check("arst_cnts", 32'({issued_cnt, hit_cnt, miss_cnt}), 32'd0);
        exp_addr_q.delete(); hit_q.delete(); exp_done_q.delete();
        v0 = valid_cycles;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_more_req", 32'(valid_cycles - v0), 32'd0);
        dmin = 0; dmax = 0;
        run_replay(4, 16'($urandom), 1'b0, '0, '0, e);
        wait_done(40, lat);

        // Full-depth replay; loads while busy must be ignored.
        for (int i = 0; i < 16; i++) load(4'(i), $urandom);
        run_replay(16, 16'($urandom), 1'b0, '0, '0, e);
        load_we = 1'b1; load_addr = 4'd5; load_data = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        load_we = 1'b0;
        wait_done(100, lat);

        // Randomized replays; the first also loads entry 0 in the start cycle.
        rand_ready = 1'b1; dmin = 0; dmax = 2;
        for (int it = 0; it < 8; it++) begin
            spur_en = 1'($urandom);
            for (int k = 0; k < 2; k++) load(4'($urandom), $urandom);
            run_replay(it == 0 ? 16 : int'($urandom_range(1, 16)), 16'($urandom),
                       it == 0, 4'd0, $urandom, e);
            wait_done(300, lat);
        end
        spur_en = 1'b0;

        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
